// File: rtl/snake_pkg.sv
// Shared definitions for the snake game pipeline: direction and FSM state
// encodings, grid geometry (also used by the fruit stage) and default timing.
// Optional feature macro consumed by this slice: SNAKE_WALL_WRAP_EN.
package snake_pkg;

    // Direction encoding; opposite directions differ only in bit 0.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Head FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    // Pixel grid shared with the fruit stage.
    localparam int X_MIN   = 140;
    localparam int X_MAX   = 908;
    localparam int Y_MIN   = 140;
    localparam int Y_MAX   = 908;
    localparam int STEP_X  = 32;
    localparam int STEP_Y  = 64;
    localparam int START_X = 396;
    localparam int START_Y = 396;

    // Defaults for the tunable parameters of the head datapath.
    localparam int DEF_MOVE_DIV  = 2250;
    localparam int DEF_MAX_LEN   = 63;
    localparam int START_LEN     = 3;

    // Direction that would reverse the snake onto itself.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/snake_head_datapath_move_tick_gen.sv
// Move-rate divider: counts 0..DIV-1 while enabled and pulses tick on the
// last count, wrapping to 0 in the same cycle. clr holds the count at 0.
module move_tick_gen #(
    parameter int DIV = 2250
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Divider counter: synchronous clear has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/snake_head_datapath.sv
// Snake head datapath: moves the head one grid cell per move tick in the
// player-selected direction, grows length/score on fruit_en, and detects
// wall exits. Defining SNAKE_WALL_WRAP_EN makes walls wrap instead of kill.
//
// FSM: IDLE --start--> RUN --wall exit on a tick--> DEAD --start--> RUN.
// dbg_state exposes the FSM state (ST_IDLE/ST_RUN/ST_DEAD) for checkers.
module snake_head_datapath
    import snake_pkg::*;
#(
    parameter int MOVE_DIV = DEF_MOVE_DIV,
    parameter int MAX_LEN  = DEF_MAX_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        fruit_en,
    output logic [11:0] snake_x,
    output logic [11:0] snake_y,
    output logic [5:0]  snake_len,
    output logic [7:0]  score,
    output logic        game_over,
    output logic        move_tick,
    output logic [1:0]  dbg_state
);

    localparam logic [11:0] X_LO      = 12'(X_MIN);
    localparam logic [11:0] X_HI      = 12'(X_MAX);
    localparam logic [11:0] Y_LO      = 12'(Y_MIN);
    localparam logic [11:0] Y_HI      = 12'(Y_MAX);
    localparam logic [11:0] SX        = 12'(STEP_X);
    localparam logic [11:0] SY        = 12'(STEP_Y);
    localparam logic [11:0] X_LEFT_OK = 12'(X_MIN + STEP_X);
    localparam logic [11:0] X_RGHT_OK = 12'(X_MAX - STEP_X);
    localparam logic [11:0] Y_UP_OK   = 12'(Y_MIN + STEP_Y);
    localparam logic [11:0] Y_DOWN_OK = 12'(Y_MAX - STEP_Y);
    localparam logic [11:0] X_START   = 12'(START_X);
    localparam logic [11:0] Y_START   = 12'(START_Y);
    localparam logic [5:0]  LEN_START = 6'(START_LEN);
    localparam logic [5:0]  LEN_MAX   = 6'(MAX_LEN);

    logic [1:0]  state;
    logic [1:0]  direction;
    logic [1:0]  pending;
    logic        running;
    logic        restart;
    logic        req_valid;
    logic [1:0]  req_dir;
    logic [1:0]  committed;
    logic        accept;
    logic        wall_hit;
    logic [11:0] next_x;
    logic [11:0] next_y;

    assign running   = (state == ST_RUN);
    assign restart   = (state == ST_DEAD) && start;
    assign game_over = (state == ST_DEAD);
    assign dbg_state = state;

    move_tick_gen #(
        .DIV (MOVE_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (running),
        .clr   (!running),
        .tick  (move_tick)
    );

    // Button decode with up > down > left > right priority. On a tick cycle
    // the pending direction becomes the committed one, so reversal is judged
    // against it; the move itself still uses the pending value from before
    // this cycle's request.
    always_comb begin
        req_valid = btn_up | btn_down | btn_left | btn_right;
        req_dir   = DIR_RIGHT;
        if (btn_up)        req_dir = DIR_UP;
        else if (btn_down) req_dir = DIR_DOWN;
        else if (btn_left) req_dir = DIR_LEFT;
        committed = move_tick ? pending : direction;
        accept    = req_valid && (req_dir != opposite_dir(committed))
                    && (state != ST_DEAD);
    end

    // Next head cell in the pending direction, with the wall test made on the
    // current position so the 12-bit coordinates never underflow.
    always_comb begin
        wall_hit = 1'b0;
        next_x   = snake_x;
        next_y   = snake_y;
        case (pending)
            DIR_UP: begin
                if (snake_y < Y_UP_OK) begin
`ifdef SNAKE_WALL_WRAP_EN
                    next_y = Y_HI;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_y = snake_y - SY;
                end
            end
            DIR_DOWN: begin
                if (snake_y > Y_DOWN_OK) begin
`ifdef SNAKE_WALL_WRAP_EN
                    next_y = Y_LO;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_y = snake_y + SY;
                end
            end
            DIR_LEFT: begin
                if (snake_x < X_LEFT_OK) begin
`ifdef SNAKE_WALL_WRAP_EN
                    next_x = X_HI;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_x = snake_x - SX;
                end
            end
            default: begin
                if (snake_x > X_RGHT_OK) begin
`ifdef SNAKE_WALL_WRAP_EN
                    next_x = X_LO;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_x = snake_x + SX;
                end
            end
        endcase
    end

    // FSM and direction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            direction <= DIR_RIGHT;
            pending   <= DIR_RIGHT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) pending <= req_dir;
                    if (start)  state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (accept) pending <= req_dir;
                    if (move_tick) begin
                        direction <= pending;
                        if (wall_hit) state <= ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (start) begin
                        state     <= ST_RUN;
                        direction <= DIR_RIGHT;
                        pending   <= DIR_RIGHT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Head position: advance on a legal tick, reload on restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snake_x <= X_START;
            snake_y <= Y_START;
        end else if (restart) begin
            snake_x <= X_START;
            snake_y <= Y_START;
        end else if (running && move_tick && !wall_hit) begin
            snake_x <= next_x;
            snake_y <= next_y;
        end
    end

    // Length and score: saturating growth on fruit while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snake_len <= LEN_START;
            score     <= 8'd0;
        end else if (restart) begin
            snake_len <= LEN_START;
            score     <= 8'd0;
        end else if (running && fruit_en) begin
            if (snake_len != LEN_MAX) snake_len <= snake_len + 6'd1;
            if (score != 8'hFF)       score     <= score + 8'd1;
        end
    end

endmodule
